fnd_scan_driver: RTL and testbench
==================================

Name: fnd_scan_driver

Overview:
Consumer end of the FND timing path. Divides the system clock into per-digit scan slots itself and multiplexes a 4-digit common-anode 7-segment display: it rotates the digit commons and drives the matching segment pattern. It inserts a blanking interval at each digit change to suppress ghosting. A new display value is staged and applied only at a frame boundary, so a frame never shows a mix of old and new digits.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot; legal range 2..65535.
BLANK_CYCLES, 1000, cycles at the start of each slot with all commons off; must be < SCAN_DIV.

Ports:
i_clk  input  1  system clock; the block's only clock.
i_reset_n  input  1  asynchronous, active-low reset.
i_value  input  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
i_load  input  1  single-cycle strobe; stages i_value for the next frame.
i_dp  input  4  per-digit decimal point enable, active high; sampled live.
i_digit_en  input  4  per-digit enable; a disabled digit stays dark; sampled live.
i_lz_suppress  input  1  blank leading zero digits when high; sampled live.
o_com  output  4  digit commons, active low; bit n drives digit n.
o_seg  output  8  segments, active low, {dp,g,f,e,d,c,b,a}.
o_frame_done  output  1  one-cycle pulse after digit 3's slot completes.

Behaviour:
- Reset (asynchronous on i_reset_n low):
  - o_com = 4'b1111, o_seg = 8'hFF, o_frame_done = 0.
  - Prescaler cnt = 0, digit index = 0.
  - Shadow value = 0, staging value = 0, pending flag = 0.
- Prescaler cnt counts 0..SCAN_DIV-1. At cnt == SCAN_DIV-1 it wraps to 0 and the digit index advances 0→1→2→3→0.
- Frame wrap is defined as cnt == SCAN_DIV-1 and index == 3.
- Value staging:
  - On i_load outside a wrap cycle: staging <= i_value and pending <= 1.
  - On a wrap cycle with pending set: shadow <= staging and pending <= 0.
  - i_load on the wrap cycle itself: shadow <= i_value directly, pending <= 0. The new value is shown from the next frame.
  - Multiple i_load strobes within one frame: the last one wins.
- Leading-zero suppression:
  - With i_lz_suppress high, digit n is suppressed if shadow nibbles n..3 are all zero.
  - Digit 0 is never suppressed.
- Digit n is lit when all of the following hold: index == n, cnt >= BLANK_CYCLES, i_digit_en[n] = 1, and digit n is not suppressed.
- Registered outputs, one cycle latency from (cnt, index):
  - o_com: only the lit digit's bit is low; all ones otherwise.
  - o_seg: hex-to-7seg encoding of the indexed shadow nibble, with bit7 = ~i_dp[index]. It is forced to 8'hFF whenever no digit is lit.
- o_frame_done is high for exactly the one cycle following a frame wrap.
- At most one o_com bit is ever low. o_com is all ones for at least BLANK_CYCLES cycles at every digit change.
- Reset asserted mid-frame:
  - Outputs go dark immediately (asynchronously).
  - Any pending staged value is discarded.
  - After reset release, the scan restarts at digit 0, cnt 0.
- Encoding, active-low: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E (dp off).

Decomposition:
- Shared package fnd_pkg holds:
  - the 16-entry segment encoding constants;
  - SEG_BLANK = 8'hFF and COM_OFF = 4'b1111;
  - the digit index width constant (2).
- One sub-module, hex_to_7seg: purely combinational, 4-bit nibble plus dp in, 8-bit active-low segment pattern out. Also reusable by other display blocks.
- Prescaler, index counter, staging logic and output registers live in fnd_scan_driver.

Test Plan:
All tests use SCAN_DIV=8, BLANK_CYCLES=2.
1. Hold reset low, then release with no load → every digit slot shows 8'hC0 during cycles 2..7 of the slot. o_com steps 1110, 1101, 1011, 0111, each preceded by 2 cycles of 1111. o_frame_done pulses every 32 cycles.
2. i_load with i_value=16'h12AF mid-frame → the current frame keeps showing 0. From the next frame, digit 0=8E, 1=88, 2=A4, 3=F9.
3. i_value=16'h0005, i_lz_suppress=1 → digits 3..1 stay dark (o_com never low for them) and digit 0 shows 92. Set i_lz_suppress=0 → digits 3..1 show C0.
4. i_load on the frame-wrap cycle, and two loads within one frame → the wrap-cycle value appears the very next frame. In the two-load case only the second value is displayed.
5. i_dp=4'b0100 and i_digit_en=4'b1011 → digit 2 stays dark despite its dp bit. Other digits display with bit7=1.
6. Assert i_reset_n low mid-slot on digit 2 while a load is pending → o_com=1111 and o_seg=FF without waiting for a clock edge. After release the scan restarts at digit 0 showing 0, with the pending value lost.

Source files
------------

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants for the 7-segment display blocks.
//   SEG_ENC    : active-low {dp,g,f,e,d,c,b,a} pattern per hex digit (dp off)
//   SEG_BLANK  : all segments dark
//   COM_OFF    : all digit commons off
//   DIGIT_W    : width of the digit index
package fnd_pkg;

  localparam int unsigned DIGIT_W    = 2;
  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] COM_OFF   = 4'b1111;

  localparam logic [7:0] SEG_ENC [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational hex nibble to active-low 7-segment pattern.
//   nibble : hex digit to display
//   dp     : decimal point enable, active high
//   seg_c  : active-low {dp,g,f,e,d,c,b,a}
module hex_to_7seg
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg_c
);

  always_comb begin
    seg_c = {~dp, SEG_ENC[nibble][6:0]};
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: multiplexed 4-digit common-anode 7-segment driver.
//   i_clk, i_reset_n : clock, async active-low reset
//   i_value, i_load  : display value and strobe; applied at the next frame boundary
//   i_dp             : per-digit decimal point (live)
//   i_digit_en       : per-digit enable (live)
//   i_lz_suppress    : blank leading zero digits (live)
//   o_com            : active-low digit commons
//   o_seg            : active-low segments {dp,g,f,e,d,c,b,a}
//   o_frame_done     : one-cycle pulse after digit 3's slot ends
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_value,
  input  logic        i_load,
  input  logic [3:0]  i_dp,
  input  logic [3:0]  i_digit_en,
  input  logic        i_lz_suppress,
  output logic [3:0]  o_com,
  output logic [7:0]  o_seg,
  output logic        o_frame_done
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [DIGIT_W-1:0] IDX_LAST  = DIGIT_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]   cnt;
  logic [DIGIT_W-1:0] idx;
  logic [15:0]        shadow;
  logic [15:0]        staging;
  logic               pending;

  logic               slot_end_c;
  logic               frame_wrap_c;
  logic [3:0]         nibble_c;
  logic               upper_zero_c;
  logic               suppress_c;
  logic               lit_c;
  logic [7:0]         seg_c;

  // Slot and frame boundaries
  always_comb begin
    slot_end_c   = (cnt == CNT_LAST);
    frame_wrap_c = slot_end_c && (idx == IDX_LAST);
  end

  // Current digit, leading-zero test (nibbles idx..3 all zero) and lit decision
  always_comb begin
    nibble_c     = shadow[{idx, 2'b00} +: 4];
    upper_zero_c = 1'b0;
    case (idx)
      2'd0:    upper_zero_c = (shadow == 16'h0);
      2'd1:    upper_zero_c = (shadow[15:4] == 12'h0);
      2'd2:    upper_zero_c = (shadow[15:8] == 8'h0);
      default: upper_zero_c = (shadow[15:12] == 4'h0);
    endcase
    suppress_c = i_lz_suppress && (idx != 2'd0) && upper_zero_c;
    lit_c      = (cnt >= CNT_BLANK) && i_digit_en[idx] && !suppress_c;
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble_c),
    .dp     (i_dp[idx]),
    .seg_c  (seg_c)
  );

  // Prescaler and digit index
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end_c) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Value staging: a load is held until the frame wrap so frames never mix values
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shadow  <= '0;
      staging <= '0;
      pending <= 1'b0;
    end else if (frame_wrap_c) begin
      if (i_load) begin
        shadow <= i_value;
      end else if (pending) begin
        shadow <= staging;
      end
      pending <= 1'b0;
    end else if (i_load) begin
      staging <= i_value;
      pending <= 1'b1;
    end
  end

  // Registered display outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_com        <= COM_OFF;
      o_seg        <= SEG_BLANK;
      o_frame_done <= 1'b0;
    end else begin
      o_com        <= lit_c ? ~(4'b0001 << idx) : COM_OFF;
      o_seg        <= lit_c ? seg_c : SEG_BLANK;
      o_frame_done <= frame_wrap_c;
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver: self-checking bench for fnd_scan_driver (SCAN_DIV=8, BLANK_CYCLES=2).
module tb_fnd_scan_driver;

  localparam int SD = 8;
  localparam int BC = 2;

  typedef struct packed {
    logic [15:0] value;
    logic        lz;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [31:0] seg;   // expected {d3,d2,d1,d0}; 8'hFF means dark
  } vec_t;

  typedef struct packed {
    logic [3:0] com;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic [3:0]  en;
  logic        lz;
  logic [3:0]  o_com;
  logic [7:0]  o_seg;
  logic        o_frame_done;

  int checks;
  int fails;
  bit sb_en;
  exp_t sb_q[$];

  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // reference model state
  int          m_cnt;
  int          m_idx;
  logic [15:0] m_shadow;
  logic [15:0] m_staging;
  bit          m_pending;

  vec_t vecs [9];

  fnd_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_value       (value),
    .i_load        (load),
    .i_dp          (dp),
    .i_digit_en    (en),
    .i_lz_suppress (lz),
    .o_com         (o_com),
    .o_seg         (o_seg),
    .o_frame_done  (o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_shadow = '0; m_staging = '0; m_pending = 0;
  endtask

  // Model: predict the outputs of each edge from pre-edge state and inputs
  initial begin
    exp_t e;
    logic [3:0] nib;
    logic sup, lit;
    forever begin
      @(posedge clk);
      if (sb_en) begin
        nib = 4'(m_shadow >> (4 * m_idx));
        sup = lz && (m_idx != 0) && ((m_shadow >> (4 * m_idx)) == 16'h0);
        lit = (m_cnt >= BC) && en[m_idx] && !sup;
        e.seg = lit ? {~dp[m_idx], seg_tab[nib][6:0]} : 8'hFF;
        e.com = lit ? 4'(~(4'b0001 << m_idx)) : 4'hF;
        e.fd  = (m_cnt == SD - 1) && (m_idx == 3);
        sb_q.push_back(e);
        if (e.fd) begin
          if (load) m_shadow = value;
          else if (m_pending) m_shadow = m_staging;
          m_pending = 0;
        end else if (load) begin
          m_staging = value;
          m_pending = 1;
        end
        if (m_cnt == SD - 1) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % 4;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Scoreboard compare, #1 after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_en && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_outputs", 32'({o_com, o_seg, o_frame_done}), 32'(e));
      end
    end
  end

  task automatic wait_fd();
    bit ok;
    ok = 0;
    for (int n = 0; n < 80 && !ok; n++) begin
      @(posedge clk);
      #1;
      ok = o_frame_done;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL wait_frame_done timeout actual=0 required=1");
    end
  endtask

  // Walk one frame, checking blank phase (cnt 1) and lit phase (cnt 4) per digit
  task automatic check_frame(input string name, input logic [31:0] seg, input bit wait_first);
    logic [7:0] es;
    logic [3:0] ec;
    if (wait_first) wait_fd();
    for (int k = 0; k < 4 * SD; k++) begin
      int d, c;
      @(posedge clk);
      #1;
      d = k / SD;
      c = k % SD;
      if (c == 1 || c == 4) begin
        es = (c == 1) ? 8'hFF : seg[d*8 +: 8];
        ec = (es == 8'hFF) ? 4'hF : 4'(~(4'b0001 << d));
        chk({name, "_com"}, 32'(o_com), 32'(ec));
        chk({name, "_seg"}, 32'(o_seg), 32'(es));
      end
    end
  endtask

  initial begin
    int n;
    checks = 0; fails = 0; sb_en = 0;
    rst_n = 0; load = 0; value = '0; dp = '0; en = 4'hF; lz = 0;
    model_reset();

    vecs[0] = '{value:16'h12AF, lz:1'b0, dp:4'b0000, en:4'b1111, seg:32'hF9A4888E};
    vecs[1] = '{value:16'h0005, lz:1'b1, dp:4'b0000, en:4'b1111, seg:32'hFFFFFF92};
    vecs[2] = '{value:16'h0005, lz:1'b0, dp:4'b0000, en:4'b1111, seg:32'hC0C0C092};
    vecs[3] = '{value:16'h0123, lz:1'b0, dp:4'b0100, en:4'b1011, seg:32'hC0FFA4B0};
    vecs[4] = '{value:16'h4567, lz:1'b0, dp:4'b0000, en:4'b1111, seg:32'h999282F8};
    vecs[5] = '{value:16'h89AB, lz:1'b0, dp:4'b1111, en:4'b1111, seg:32'h00100803};
    vecs[6] = '{value:16'hCDEF, lz:1'b0, dp:4'b0000, en:4'b1111, seg:32'hC6A1868E};
    vecs[7] = '{value:16'h0100, lz:1'b1, dp:4'b0000, en:4'b1111, seg:32'hFFF9C0C0};
    vecs[8] = '{value:16'h0000, lz:1'b1, dp:4'b0001, en:4'b1111, seg:32'hFFFFFF40};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_com", 32'(o_com), 32'h0000000F);
    chk("reset_seg", 32'(o_seg), 32'h000000FF);
    chk("reset_fd", 32'(o_frame_done), 32'h0);
    @(negedge clk);
    model_reset();
    sb_en = 1;
    rst_n = 1;

    // No load: all zeros, frame period 32
    wait_fd();
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!o_frame_done && n < 100);
    chk("frame_period", 32'(n), 32'(4 * SD));
    check_frame("zero_frame", 32'hC0C0C0C0, 1'b0);

    // Table-driven values, loaded mid-frame
    for (int i = 0; i < 9; i++) begin
      wait_fd();
      @(negedge clk);
      value = vecs[i].value; lz = vecs[i].lz; dp = vecs[i].dp; en = vecs[i].en;
      load = 1;
      @(negedge clk);
      load = 0;
      check_frame($sformatf("vec%0d", i), vecs[i].seg, 1'b1);
    end

    // Load on the frame-wrap cycle itself
    lz = 0; dp = '0; en = 4'hF;
    wait_fd();
    repeat (4 * SD - 1) @(posedge clk);
    @(negedge clk);
    value = 16'h7E3D;
    load = 1;
    @(posedge clk);
    #1;
    load = 0;
    chk("wrap_load_fd", 32'(o_frame_done), 32'h1);
    check_frame("wrap_load", 32'hF886B0A1, 1'b0);

    // Two loads in one frame: the last wins
    wait_fd();
    @(negedge clk);
    value = 16'h1111; load = 1;
    @(negedge clk);
    load = 0;
    repeat (5) @(negedge clk);
    value = 16'h2468; load = 1;
    @(negedge clk);
    load = 0;
    check_frame("two_loads", 32'hA4998280, 1'b1);

    // Reset mid-slot on digit 2 with a pending load
    wait_fd();
    @(negedge clk);
    value = 16'hBEEF; load = 1;
    @(negedge clk);
    load = 0;
    repeat (19) @(posedge clk);
    #1;
    chk("pre_reset_com", 32'(o_com), 32'h0000000B);
    #2;
    sb_en = 0;
    rst_n = 0;
    #1;
    chk("async_reset_com", 32'(o_com), 32'h0000000F);
    chk("async_reset_seg", 32'(o_seg), 32'h000000FF);
    repeat (2) @(negedge clk);
    sb_q.delete();
    model_reset();
    sb_en = 1;
    rst_n = 1;
    repeat (BC + 1) @(posedge clk);
    #1;
    chk("restart_com", 32'(o_com), 32'h0000000E);
    chk("restart_seg", 32'(o_seg), 32'h000000C0);
    check_frame("after_reset", 32'hC0C0C0C0, 1'b1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
